// File: rtl/decryptor_if.sv
// Block-transfer interface of the AES-128 decryptor: valid/ready on the input side, valid/yumi on the output side.
// slave = decryptor side, master = producer/consumer side.
interface decryptor_if;
    logic [127:0] data_i;
    logic         data_v_i;
    logic         ready_o;
    logic [127:0] data_o;
    logic         data_v_o;
    logic         yumi_i;

    modport slave (
        input  data_i, data_v_i, yumi_i,
        output data_o, data_v_o, ready_o
    );

    modport master (
        output data_i, data_v_i, yumi_i,
        input  data_o, data_v_o, ready_o
    );
endinterface

// File: rtl/decryptor.sv
// Iterative AES-128 inverse cipher (one round per clock) with round keys from an on-chip key schedule.
// Optional macro DECRYPTOR_EARLY_READY_EN: accept the next block on the same edge the result is taken.
package decryptor_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

endpackage

module inv_sub_byte (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    assign byte_o = decryptor_pkg::inv_sbox(byte_i);
endmodule

module inv_shiftrows (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    // Byte index = row + 4*col; row r rotates right by r.
    always_comb begin
        state_o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                state_o[127 - 8*(r + 4*c) -: 8] = state_i[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
    end
endmodule

module inv_mix_columns (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    always_comb begin : mix
        logic [7:0] a0, a1, a2, a3;
        state_o = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = state_i[127 - 32*c      -: 8];
            a1 = state_i[127 - 32*c - 8  -: 8];
            a2 = state_i[127 - 32*c - 16 -: 8];
            a3 = state_i[127 - 32*c - 24 -: 8];
            state_o[127 - 32*c      -: 8] = decryptor_pkg::gmul(a0, 8'h0e) ^ decryptor_pkg::gmul(a1, 8'h0b)
                                          ^ decryptor_pkg::gmul(a2, 8'h0d) ^ decryptor_pkg::gmul(a3, 8'h09);
            state_o[127 - 32*c - 8  -: 8] = decryptor_pkg::gmul(a0, 8'h09) ^ decryptor_pkg::gmul(a1, 8'h0e)
                                          ^ decryptor_pkg::gmul(a2, 8'h0b) ^ decryptor_pkg::gmul(a3, 8'h0d);
            state_o[127 - 32*c - 16 -: 8] = decryptor_pkg::gmul(a0, 8'h0d) ^ decryptor_pkg::gmul(a1, 8'h09)
                                          ^ decryptor_pkg::gmul(a2, 8'h0e) ^ decryptor_pkg::gmul(a3, 8'h0b);
            state_o[127 - 32*c - 24 -: 8] = decryptor_pkg::gmul(a0, 8'h0b) ^ decryptor_pkg::gmul(a1, 8'h0d)
                                          ^ decryptor_pkg::gmul(a2, 8'h09) ^ decryptor_pkg::gmul(a3, 8'h0e);
        end
    end
endmodule

module addroundkey (
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    output logic [127:0] state_o
);
    assign state_o = state_i ^ key_i;
endmodule

module key_mem #(
    parameter logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f
) (
    input  logic [3:0]   round_i,
    output logic [127:0] rk_o
);
    logic [10:0][127:0] rk_tab;

    // The key is a constant, so this whole expansion folds to an 11-entry table.
    always_comb begin : expand
        logic [43:0][31:0] w;
        logic [31:0]       t;
        logic [7:0]        rc;
        w  = '0;
        t  = '0;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = KEY[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {decryptor_pkg::sbox(t[23:16]), decryptor_pkg::sbox(t[15:8]),
                      decryptor_pkg::sbox(t[7:0]),   decryptor_pkg::sbox(t[31:24])} ^ {rc, 24'h0};
                rc = decryptor_pkg::xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        rk_tab = '0;
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end

    assign rk_o = (round_i <= 4'd10) ? rk_tab[round_i] : '0;
endmodule

// state   | meaning
// S_RESET | one cycle after reset release, nothing accepted
// S_READY | waiting for a ciphertext block
// S_BUSY  | running rounds round_cnt..0, one per clock
// S_DONE  | plaintext valid on data_o until yumi
module decryptor #(
    parameter int           NUM_ROUNDS = 10,
    parameter logic [127:0] KEY        = 128'h000102030405060708090a0b0c0d0e0f
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    decryptor_if.slave  bus
);
    typedef enum logic [1:0] {S_RESET, S_READY, S_BUSY, S_DONE} state_e;

    localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

    state_e       fsm_q, fsm_d;
    logic [3:0]   round_cnt_q, round_cnt_d;
    logic [127:0] block_q, block_d;
    logic [127:0] data_q, data_d;
    logic         data_v_q, data_v_d;
    logic         ready_q, ready_d;

    logic [3:0]   rk_round;
    logic [127:0] rk, isr, isb, ark, imc, load_w;

    assign rk_round = (fsm_q == S_BUSY) ? round_cnt_q : 4'(NUM_ROUNDS);

    key_mem #(.KEY(KEY)) u_key_mem (.round_i(rk_round), .rk_o(rk));
    inv_shiftrows u_isr (.state_i(block_q), .state_o(isr));
    for (genvar i = 0; i < 16; i++) begin : g_isb
        inv_sub_byte u_isb (.byte_i(isr[8*i +: 8]), .byte_o(isb[8*i +: 8]));
    end
    addroundkey     u_ark_rnd (.state_i(isb),         .key_i(rk), .state_o(ark));
    addroundkey     u_ark_in  (.state_i(bus.data_i),  .key_i(rk), .state_o(load_w));
    inv_mix_columns u_imc     (.state_i(ark),         .state_o(imc));

    always_comb begin
        fsm_d       = fsm_q;
        round_cnt_d = round_cnt_q;
        block_d     = block_q;
        data_d      = data_q;
        case (fsm_q)
            S_RESET: fsm_d = S_READY;
            S_READY: begin
                if (bus.data_v_i) begin
                    block_d     = load_w;
                    round_cnt_d = LAST_CNT;
                    fsm_d       = S_BUSY;
                end
            end
            S_BUSY: begin
                if (round_cnt_q == 4'd0) begin
                    data_d = ark;
                    fsm_d  = S_DONE;
                end else begin
                    block_d     = imc;
                    round_cnt_d = round_cnt_q - 4'd1;
                end
            end
            S_DONE: begin
`ifdef DECRYPTOR_EARLY_READY_EN
                if (bus.yumi_i && bus.data_v_i) begin
                    block_d     = load_w;
                    round_cnt_d = LAST_CNT;
                    fsm_d       = S_BUSY;
                end else if (bus.yumi_i) begin
                    fsm_d = S_READY;
                end
`else
                if (bus.yumi_i) fsm_d = S_READY;
`endif
            end
            default: fsm_d = S_RESET;
        endcase
        data_v_d = (fsm_d == S_DONE);
        ready_d  = (fsm_d == S_READY);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fsm_q       <= S_RESET;
            round_cnt_q <= '0;
            block_q     <= '0;
            data_q      <= '0;
            data_v_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            round_cnt_q <= round_cnt_d;
            block_q     <= block_d;
            data_q      <= data_d;
            data_v_q    <= data_v_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.data_o   = data_q;
    assign bus.data_v_o = data_v_q;
`ifdef DECRYPTOR_EARLY_READY_EN
    assign bus.ready_o  = ready_q | ((fsm_q == S_DONE) & bus.yumi_i);
`else
    assign bus.ready_o  = ready_q;
`endif
endmodule

// File: tb/tb_decryptor.sv
// Self-checking bench for decryptor: FIPS-197 vector, encrypt/decrypt round trip, backpressure,
// busy-drop, mid-block reset and back-to-back timing (with or without DECRYPTOR_EARLY_READY_EN).
module tb_decryptor;
    logic clk_i = 1'b0;
    logic reset_n_i;

    decryptor_if bus();

    decryptor u_dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];
    logic [127:0] rk_tb [0:10];

    localparam logic [127:0] TB_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    // ---------------- reference AES encryptor ----------------
    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (m_gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [7:0] sbox_tb [0:255];

    function automatic logic [127:0] m_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(r + 4*c) -: 8] = sbox_tb[s[127 - 8*(r + 4*((c + r) % 4)) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];      a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];      a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = m_gmul(a0, 8'h02) ^ m_gmul(a1, 8'h03) ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ m_gmul(a1, 8'h02) ^ m_gmul(a2, 8'h03) ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ m_gmul(a2, 8'h02) ^ m_gmul(a3, 8'h03);
            o[103 - 32*c -: 8] = m_gmul(a0, 8'h03) ^ a1 ^ a2 ^ m_gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] m_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_tb[0];
        for (int r = 1; r < 10; r++) s = m_mix(m_sub_shift(s)) ^ rk_tb[r];
        return m_sub_shift(s) ^ rk_tb[10];
    endfunction

    task automatic init_model();
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 256; i++) sbox_tb[i] = m_sbox(8'(i));
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = TB_KEY[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]], sbox_tb[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tb[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- transfer helpers (phase: 1 time unit after posedge) ----------------
    task automatic wait_valid(input int budget, output int ncyc, output bit ok, output bit rdy_seen);
        ncyc = 0; ok = 1'b1; rdy_seen = 1'b0;
        while (bus.data_v_o !== 1'b1) begin
            if (ncyc >= budget) begin ok = 1'b0; return; end
            if (bus.ready_o !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk_i); #1;
            ncyc++;
        end
    endtask

    task automatic send_block(input string tag, input logic [127:0] ct, input logic [127:0] pt);
        int n = 0;
        while (bus.ready_o !== 1'b1 && n < 40) begin @(posedge clk_i); #1; n++; end
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s send: ready_o=%b, required 1 within 40 cycles", tag, bus.ready_o);
            return;
        end
        bus.data_i = ct; bus.data_v_i = 1'b1;
        @(posedge clk_i); #1;
        bus.data_v_i = 1'b0;
        exp_q.push_back(pt);
    endtask

    task automatic recv_block(input string tag, input int exp_lat);
        int n; bit ok; bit rdy_seen; logic [127:0] exp;
        wait_valid(40, n, ok, rdy_seen);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout: data_v_o=%b, required 1 within 40 cycles", tag, bus.data_v_o);
            return;
        end
        if (exp_lat >= 0) begin
            checks++;
            if (n !== exp_lat || rdy_seen) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles ready_while_busy=%b, required %0d and 0", tag, n, rdy_seen, exp_lat);
            end
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (bus.data_o !== exp) begin
            errors++;
            $display("FAIL %s data: data_o=%h, required %h", tag, bus.data_o, exp);
        end
        bus.yumi_i = 1'b1;
        @(posedge clk_i); #1;
        bus.yumi_i = 1'b0;
        checks++;
        if (bus.data_v_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s after_yumi: data_v_o=%b ready_o=%b, required 0 and 1", tag, bus.data_v_o, bus.ready_o);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n_i = 1'b0; bus.data_v_i = 1'b0; bus.yumi_i = 1'b0; bus.data_i = '0;
        #1;
        checks++;
        if (bus.data_v_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.data_o !== 128'h0) begin
            errors++;
            $display("FAIL reset_hold: data_v_o=%b ready_o=%b data_o=%h, required 0 0 0", bus.data_v_o, bus.ready_o, bus.data_o);
        end
        @(posedge clk_i); #3;
        reset_n_i = 1'b1;
        #1;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready_o=%b, required 0", bus.ready_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.data_v_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: ready_o=%b data_v_o=%b, required 1 and 0", bus.ready_o, bus.data_v_o);
        end
    endtask

    task automatic test_fips();
        send_block("fips", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
        recv_block("fips", 10);
    endtask

    task automatic test_roundtrip();
        logic [127:0] pt;
        for (int i = 0; i < 1000; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            send_block("roundtrip", m_encrypt(pt), pt);
            recv_block("roundtrip", 10);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, hold;
        int n; bit ok; bit rdy_seen; int bad;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block("backpressure", m_encrypt(pt), pt);
        wait_valid(40, n, ok, rdy_seen);
        checks++;
        if (!ok || n !== 10) begin
            errors++;
            $display("FAIL backpressure latency: got %0d cycles valid=%b, required 10 and 1", n, ok);
        end
        hold = bus.data_o;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            if (bus.data_v_o !== 1'b1 || bus.data_o !== hold || bus.ready_o !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL backpressure hold: %0d bad cycles, required 0", bad);
        end
        checks++;
        if (bus.data_o !== exp_q[0]) begin
            errors++;
            $display("FAIL backpressure data: data_o=%h, required %h", bus.data_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
        bus.yumi_i = 1'b1;
        @(posedge clk_i); #1;
        bus.yumi_i = 1'b0;
        checks++;
        if (bus.data_v_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL backpressure release: data_v_o=%b ready_o=%b, required 0 and 1", bus.data_v_o, bus.ready_o);
        end
        bus.yumi_i = 1'b1;
        repeat (2) begin @(posedge clk_i); #1; end
        bus.yumi_i = 1'b0;
        checks++;
        if (bus.data_v_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.data_o !== pt) begin
            errors++;
            $display("FAIL stray_yumi: data_v_o=%b ready_o=%b data_o=%h, required 0 1 %h", bus.data_v_o, bus.ready_o, bus.data_o, pt);
        end
    endtask

    task automatic test_busy_drop();
        logic [127:0] pt;
        int bad;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block("busy_drop", m_encrypt(pt), pt);
        for (int k = 0; k < 9; k++) begin
            bus.data_v_i = ~bus.data_v_i;
            bus.data_i   = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk_i); #1;
        end
        bus.data_v_i = 1'b0;
        recv_block("busy_drop", 1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            if (bus.data_v_o !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL busy_drop phantom: %0d cycles with data_v_o=1, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt;
        int bad;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block("reset_mid", m_encrypt(pt), pt);
        repeat (4) @(posedge clk_i);
        #3 reset_n_i = 1'b0;
        #1;
        checks++;
        if (bus.data_v_o !== 1'b0 || bus.data_o !== 128'h0 || bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid async: data_v_o=%b ready_o=%b data_o=%h, required 0 0 0", bus.data_v_o, bus.ready_o, bus.data_o);
        end
        exp_q.delete();
        @(posedge clk_i); #3;
        reset_n_i = 1'b1;
        #1;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid release: ready_o=%b, required 0", bus.ready_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid ready: ready_o=%b, required 1", bus.ready_o);
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            if (bus.data_v_o !== 1'b0 || bus.data_o !== 128'h0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_mid discard: %0d cycles with stale output, required 0", bad);
        end
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block("reset_recover", m_encrypt(pt), pt);
        recv_block("reset_recover", 10);
    endtask

    task automatic test_back_to_back();
        logic [127:0] pa, pb;
        int n; bit ok; bit rdy_seen; int extra; int exp_gap; logic exp_rdy;
`ifdef DECRYPTOR_EARLY_READY_EN
        exp_gap = 10; exp_rdy = 1'b1;
`else
        exp_gap = 11; exp_rdy = 1'b0;
`endif
        pa = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        send_block("b2b_a", m_encrypt(pa), pa);
        wait_valid(40, n, ok, rdy_seen);
        checks++;
        if (!ok || bus.data_o !== pa) begin
            errors++;
            $display("FAIL b2b first: valid=%b data_o=%h, required 1 and %h", ok, bus.data_o, pa);
        end
        void'(exp_q.pop_front());
        bus.data_i = m_encrypt(pb); bus.data_v_i = 1'b1; bus.yumi_i = 1'b1;
        #1;
        checks++;
        if (bus.ready_o !== exp_rdy) begin
            errors++;
            $display("FAIL b2b ready_in_done: ready_o=%b, required %b", bus.ready_o, exp_rdy);
        end
        @(posedge clk_i); #1;
        bus.yumi_i = 1'b0;
        extra = 0;
        if (bus.ready_o === 1'b1) begin
            @(posedge clk_i); #1;
            extra = 1;
        end
        bus.data_v_i = 1'b0;
        exp_q.push_back(pb);
        wait_valid(40, n, ok, rdy_seen);
        checks++;
        if (!ok || n + extra !== exp_gap) begin
            errors++;
            $display("FAIL b2b gap: got %0d cycles from yumi edge valid=%b, required %0d", n + extra, ok, exp_gap);
        end
        recv_block("b2b_b", 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_model();
        test_reset();
        test_fips();
        test_roundtrip();
        test_backpressure();
        test_busy_drop();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
